// File: rtl/fml_video_arbiter.sv
// Two-port FML arbiter: a video fetch port and a CPU port share one FML master.
// Video wins by default; a starvation counter forces a CPU grant after starve_max video grants.
module fml_video_arbiter #(
  parameter int fml_depth  = 25,
  parameter int starve_max = 4
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic [fml_depth-1:0] vid_adr,
  input  logic                 vid_stb,
  output logic                 vid_ack,
  output logic [15:0]          vid_di,

  input  logic [fml_depth-1:0] cpu_adr,
  input  logic                 cpu_stb,
  input  logic                 cpu_we,
  input  logic [1:0]           cpu_sel,
  input  logic [15:0]          cpu_do,
  output logic                 cpu_ack,
  output logic [15:0]          cpu_di,

  output logic [fml_depth-1:0] fml_adr,
  output logic                 fml_stb,
  output logic                 fml_we,
  output logic [1:0]           fml_sel,
  output logic [15:0]          fml_do,
  input  logic                 fml_ack,
  input  logic [15:0]          fml_di
);

  typedef enum logic [1:0] {IDLE, VID, CPU} state_t;

  // The counter is 3 bits wide, so a larger starve_max is clamped to its ceiling.
  localparam int              STARVE_CAP = (starve_max > 7) ? 7 : starve_max;
  localparam logic [2:0]      STARVE_LIM = 3'(STARVE_CAP);

  state_t     state;
  logic [2:0] starve_cnt;
  logic       armed;
  logic       cpu_first;

  assign cpu_first = cpu_stb && (starve_cnt >= STARVE_LIM);

  // armed keeps the first clock edge after reset release free of grants.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= 3'd0;
      armed      <= 1'b0;
      fml_adr    <= '0;
      fml_stb    <= 1'b0;
      fml_we     <= 1'b0;
      fml_sel    <= 2'b00;
      fml_do     <= 16'h0000;
      vid_ack    <= 1'b0;
      vid_di     <= 16'h0000;
      cpu_ack    <= 1'b0;
      cpu_di     <= 16'h0000;
    end else begin
      armed   <= 1'b1;
      vid_ack <= 1'b0;
      cpu_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (!cpu_stb)
            starve_cnt <= 3'd0;
          if (armed) begin
            if (vid_stb && !cpu_first) begin
              state   <= VID;
              fml_adr <= vid_adr;
              fml_we  <= 1'b0;
              fml_sel <= 2'b11;
              fml_stb <= 1'b1;
              if (cpu_stb && starve_cnt != 3'd7)
                starve_cnt <= starve_cnt + 3'd1;
            end else if (cpu_stb) begin
              state      <= CPU;
              fml_adr    <= cpu_adr;
              fml_we     <= cpu_we;
              fml_sel    <= cpu_sel;
              fml_do     <= cpu_do;
              fml_stb    <= 1'b1;
              starve_cnt <= 3'd0;
            end
          end
        end
        VID: begin
          if (fml_ack) begin
            vid_ack <= 1'b1;
            vid_di  <= fml_di;
            fml_stb <= 1'b0;
            state   <= IDLE;
          end
        end
        CPU: begin
          // Writes complete with an ack but leave the last read data in place.
          if (fml_ack) begin
            cpu_ack <= 1'b1;
            if (!fml_we)
              cpu_di <= fml_di;
            fml_stb <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
